// File: rtl/snd_pkg.sv
// Shared audio-path types and constants for the mixer / I2S output stage.
package snd_pkg;

   localparam int         I2S_SLOTS  = 64;
   localparam int         I2S_WORD   = 16;
   localparam logic [8:0] GAIN_UNITY = 9'd256;

   typedef logic signed [15:0] snd_sample_t;

   typedef struct {
      snd_sample_t l;
      snd_sample_t r;
   } snd_stereo_t;

endpackage

// File: rtl/snd_gain_ramp.sv
// Master gain register with saturating mute/unmute ramp and the L/R scaling paths.
module snd_gain_ramp
   import snd_pkg::*;
#(
   parameter int RAMP_STEP = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        tick,
   input  logic        mute,
   input  logic [15:0] in_l,
   input  logic [15:0] in_r,
   output logic [15:0] out_l,
   output logic [15:0] out_r,
   output logic [8:0]  gain
);

   localparam logic [9:0] STEP = 10'(RAMP_STEP);

   logic [9:0]         gain_up;
   logic [8:0]         gain_nx;
   logic signed [25:0] prod_l, prod_r;

   assign gain_up = {1'b0, gain} + STEP;

   always_comb begin
      gain_nx = gain;
      if (mute)
         gain_nx = ({1'b0, gain} >= STEP) ? (gain - STEP[8:0]) : 9'd0;
      else
         gain_nx = (gain_up >= {1'b0, GAIN_UNITY}) ? GAIN_UNITY : gain_up[8:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    gain <= '0;
      else if (tick) gain <= gain_nx;
   end

   // Bits [23:8] of the two's-complement product are floor(x*g/256).
   assign prod_l = 26'($signed(in_l)) * 26'($signed({1'b0, gain}));
   assign prod_r = 26'($signed(in_r)) * 26'($signed({1'b0, gain}));
   assign out_l  = 16'(prod_l >>> 8);
   assign out_r  = 16'(prod_r >>> 8);

endmodule

// File: rtl/snd_i2s_tx.sv
// Final audio stage: BCLK divider, 64-slot I2S frame serialiser and frame tick for the mixer.
module snd_i2s_tx
   import snd_pkg::*;
#(
   parameter int BCLK_DIV  = 8,
   parameter int RAMP_STEP = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic        mute,
   input  logic [15:0] snd_l,
   input  logic [15:0] snd_r,
   output logic        next_sample,
   output logic        i2s_bclk,
   output logic        i2s_lrck,
   output logic        i2s_sdat,
   output logic [8:0]  gain,
   output logic        muted
);

   localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

   logic [DW-1:0] div_ctr;
   logic [5:0]    slot, slot_nx;
   logic          div_tc, fall, tick;
   logic [4:0]    pos;
   logic          in_word;
   logic [3:0]    bidx;
   logic          bit_nx;
   logic [15:0]   scl_l, scl_r;
   snd_stereo_t   hold, shreg;

   assign div_tc  = (div_ctr == DW'(BCLK_DIV - 1));
   assign fall    = en && div_tc && i2s_bclk;
   assign slot_nx = slot + 6'd1;
   assign tick    = fall && (slot_nx == 6'd0);

   // One-bit I2S delay: word bits sit on slot positions 1..16 of each half-frame.
   assign pos     = slot_nx[4:0];
   assign in_word = (pos != 5'd0) && (pos <= 5'(I2S_WORD));
   assign bidx    = 4'(5'd16 - pos);

   always_comb begin
      bit_nx = 1'b0;
      if (in_word) bit_nx = slot_nx[5] ? shreg.r[bidx] : shreg.l[bidx];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_ctr     <= '0;
         slot        <= '0;
         i2s_bclk    <= 1'b0;
         i2s_lrck    <= 1'b0;
         i2s_sdat    <= 1'b0;
         next_sample <= 1'b0;
         hold.l      <= '0;
         hold.r      <= '0;
         shreg.l     <= '0;
         shreg.r     <= '0;
      end else if (!en) begin
         // Parked at the last slot so the first falling edge after enable starts a frame.
         div_ctr     <= '0;
         slot        <= 6'(I2S_SLOTS - 1);
         i2s_bclk    <= 1'b0;
         i2s_lrck    <= 1'b0;
         i2s_sdat    <= 1'b0;
         next_sample <= 1'b0;
      end else begin
         next_sample <= 1'b0;
         if (div_tc) begin
            div_ctr  <= '0;
            i2s_bclk <= ~i2s_bclk;
         end else begin
            div_ctr  <= div_ctr + DW'(1);
         end
         if (fall) begin
            slot        <= slot_nx;
            i2s_lrck    <= slot_nx[5];
            i2s_sdat    <= bit_nx;
            next_sample <= tick;
         end
         if (tick) begin
            hold.l <= scl_l;
            hold.r <= scl_r;
            shreg  <= hold;
         end
      end
   end

   snd_gain_ramp #(
      .RAMP_STEP (RAMP_STEP)
   ) u_gain (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick),
      .mute  (mute),
      .in_l  (snd_l),
      .in_r  (snd_r),
      .out_l (scl_l),
      .out_r (scl_r),
      .gain  (gain)
   );

   assign muted = (gain == 9'd0);

endmodule
